// File: rtl/chan_mux_reg_pkg.sv
// chan_mux_pkg: mode encodings and select-width helper shared by chan_mux_reg, rr_grant and chan_mux_reg_if
package chan_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/chan_mux_reg_if.sv
// chan_mux_reg_if: producer/consumer bus (mode, sel, in_valid/in_data/in_ready, out_valid/out_data/out_ready, out_chan with CHAN_ID_EN); slave=mux, master=environment
interface chan_mux_reg_if
  import chan_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = sel_w(CHANNELS);
  logic mode;
  logic [SEL_W-1:0] sel;
  logic [CHANNELS-1:0] in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0] in_ready;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic out_ready;
`ifdef CHAN_ID_EN
  logic [SEL_W-1:0] out_chan;
  modport slave(input mode, sel, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_chan);
  modport master(output mode, sel, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_chan);
`else
  modport slave(input mode, sel, in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
  modport master(output mode, sel, in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/chan_mux_reg_rr_grant.sv
// rr_grant: combinational grant (in_valid, ptr, mode, sel -> grant, g); fixed select or round-robin scan from ptr
module rr_grant
  import chan_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  output logic                grant,
  output logic [SEL_W-1:0]    g
);
  logic rr_hit;
  logic [SEL_W-1:0] rr_g;
  logic fx_hit;
  always_comb begin
    rr_hit = 1'b0;
    rr_g = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) idx -= CHANNELS;
      if (!rr_hit && in_valid[idx]) begin
        rr_hit = 1'b1;
        rr_g = SEL_W'(idx);
      end
    end
  end
  assign fx_hit = (int'(sel) < CHANNELS) ? in_valid[sel] : 1'b0;
  assign grant = (mode == MODE_RR) ? rr_hit : fx_hit;
  assign g = (mode == MODE_RR) ? rr_g : sel;
endmodule

// File: rtl/chan_mux_reg.sv
// chan_mux_reg: N-channel registered selector with valid/ready on clk/reset/bus(slave); out_chan present only with CHAN_ID_EN
module chan_mux_reg
  import chan_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4
) (
  input logic clk,
  input logic reset,
  chan_mux_reg_if.slave bus
);
  localparam int SEL_W = sel_w(CHANNELS);
  logic grant;
  logic [SEL_W-1:0] g;
  logic load_en;
  logic xfer;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  rr_grant #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_grant (
    .in_valid(bus.in_valid),
    .ptr(ptr_q),
    .mode(bus.mode),
    .sel(bus.sel),
    .grant(grant),
    .g(g)
  );
  assign load_en = !out_valid_q || bus.out_ready;
  assign xfer = grant && load_en && !reset;
  assign bus.in_ready = xfer ? (CHANNELS'(1) << g) : '0;
  always_comb begin
    out_valid_d = xfer ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    out_data_d = xfer ? bus.in_data[g*WIDTH +: WIDTH] : out_data_q;
    ptr_d = (xfer && bus.mode == MODE_RR) ? ((int'(g) == CHANNELS - 1) ? '0 : SEL_W'(int'(g) + 1)) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
`ifdef CHAN_ID_EN
  logic [SEL_W-1:0] out_chan_q;
  always_ff @(posedge clk) begin
    if (reset) out_chan_q <= '0;
    else if (xfer) out_chan_q <= g;
  end
  assign bus.out_chan = out_chan_q;
`endif
endmodule
